// File: rtl/seg_scroller_pkg.sv
// Shared defaults and constants for the scrolling seven-segment display block.
package seg_scroller_pkg;

  // Default FIFO depth in bytes (power of two).
  localparam int DEPTH_DEF = 8;

  // Default number of clk cycles the display rests on each scroll position.
  localparam int DWELL_DEF = 50_000_000;

  // Digit-enable mask with every digit blanked (1 = blanked).
  localparam logic [3:0] BLANK_MASK = 4'hF;

endpackage

// File: rtl/seg_byte_fifo.sv
// Byte FIFO with occupancy count and synchronous flush.
// Pushes beyond DEPTH and pops from empty are ignored internally as well,
// so level can never leave the range 0..DEPTH.
module seg_byte_fifo
  import seg_scroller_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !w_empty;

  assign head  = r_mem[r_rd_ptr];
  assign level = r_level;

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/seg_scroller.sv
// Scrolls buffered bytes across a four-digit hex display, one byte per dwell period.
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are
// both 1; in_ready depends only on current level, clear and rst (never on
// a pop in the same cycle), so a full FIFO refuses data even on a step cycle.
module seg_scroller
  import seg_scroller_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   hold,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [15:0]            num,
  output logic [3:0]             aen,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;
  logic [15:0]   r_num;
  logic [3:0]    r_aen;

  logic [7:0]    w_head;
  logic [LW-1:0] w_level;
  logic          w_step;
  logic          w_push;
  logic          w_pop;

  // Step fires on the last dwell cycle only while scrolling is not frozen.
  assign w_step   = !hold && (r_cnt == LAST);
  assign in_ready = !rst && !clear && (w_level < LW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  // Pop uses the registered level, so a byte pushed on a step cycle waits a full step.
  assign w_pop    = w_step && (w_level != '0) && !clear && !rst;

  seg_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (w_push),
    .push_data (in_data),
    .pop       (w_pop),
    .head      (w_head),
    .level     (w_level)
  );

  // Dwell counter: wraps at DWELL-1, frozen while hold is high.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (!hold) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Display shift register: each popped byte enters on the right, two digits unblank.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_num <= 16'h0000;
      r_aen <= BLANK_MASK;
    end else if (w_pop) begin
      r_num <= {r_num[7:0], w_head};
      r_aen <= {r_aen[1:0], 2'b00};
    end
  end

  assign num   = r_num;
  assign aen   = r_aen;
  assign level = w_level;

endmodule

// File: tb/tb_seg_scroller.sv
// Directed bench for seg_scroller with DEPTH=4, DWELL=4.
// Inputs are driven and outputs sampled on the falling edge; the dwell
// counter is 0 at the falling edge right after do_reset, so the first step
// happens on the 4th rising edge after that point.
module tb_seg_scroller;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        hold;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] num;
  logic [3:0]  aen;
  logic [2:0]  level;

  int tests_run;
  int tests_failed;

  seg_scroller #(
    .DEPTH (DEPTH),
    .DWELL (DWELL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .hold     (hold),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num      (num),
    .aen      (aen),
    .level    (level)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; hold = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; hold = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    tick(1);
    tests_run++;
    if (num !== 16'h0000) begin tests_failed++; $display("FAIL reset_num got %h exp 0000", num); end
    tests_run++;
    if (aen !== 4'hF) begin tests_failed++; $display("FAIL reset_aen got %h exp f", aen); end
    tests_run++;
    if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", level); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_release got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5;
    tick(1);
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd1) begin tests_failed++; $display("FAIL single_level1 got %0d exp 1", level); end
    tick(3);
    tests_run++;
    if (num !== 16'h00A5) begin tests_failed++; $display("FAIL single_num got %h exp 00a5", num); end
    tests_run++;
    if (aen !== 4'hC) begin tests_failed++; $display("FAIL single_aen got %h exp c", aen); end
    tests_run++;
    if (level !== 3'd0) begin tests_failed++; $display("FAIL single_level0 got %0d exp 0", level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = bytes[i];
      tick(1);
    end
    in_valid = 1'b0;
    tick(1);
    tests_run++;
    if (num !== 16'h0012 || aen !== 4'hC || level !== 3'd2) begin
      tests_failed++; $display("FAIL b2b_step1 got num=%h aen=%h lvl=%0d exp 0012 c 2", num, aen, level);
    end
    tick(4);
    tests_run++;
    if (num !== 16'h1234 || aen !== 4'h0 || level !== 3'd1) begin
      tests_failed++; $display("FAIL b2b_step2 got num=%h aen=%h lvl=%0d exp 1234 0 1", num, aen, level);
    end
    tick(4);
    tests_run++;
    if (num !== 16'h3456 || aen !== 4'h0 || level !== 3'd0) begin
      tests_failed++; $display("FAIL b2b_step3 got num=%h aen=%h lvl=%0d exp 3456 0 0", num, aen, level);
    end
  endtask

  task automatic test_hold();
    int accepted;
    do_reset();
    hold = 1'b1;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      #1;
      if (in_ready) accepted++;
      tick(1);
    end
    in_valid = 1'b0;
    tests_run++;
    if (accepted != 4) begin tests_failed++; $display("FAIL hold_accepted got %0d exp 4", accepted); end
    tests_run++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL hold_full got lvl=%0d rdy=%b exp 4 0", level, in_ready);
    end
    tick(3);
    tests_run++;
    if (num !== 16'h0000 || aen !== 4'hF) begin
      tests_failed++; $display("FAIL hold_frozen got num=%h aen=%h exp 0000 f", num, aen);
    end
    hold = 1'b0;
    tick(3);
    tests_run++;
    if (num !== 16'h0000) begin tests_failed++; $display("FAIL hold_prestep got %h exp 0000", num); end
    tick(1);
    tests_run++;
    if (num !== 16'h0001 || aen !== 4'hC || level !== 3'd3) begin
      tests_failed++; $display("FAIL hold_release got num=%h aen=%h lvl=%0d exp 0001 c 3", num, aen, level);
    end
  endtask

  task automatic test_full_step();
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h11 * 8'(i + 1);
      tick(1);
    end
    hold = 1'b0;
    in_data = 8'h55;
    tick(3);
    tests_run++;
    if (in_ready !== 1'b0 || level !== 3'd4) begin
      tests_failed++; $display("FAIL full_prestep got rdy=%b lvl=%0d exp 0 4", in_ready, level);
    end
    tick(1);
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd3 || num !== 16'h0011) begin
      tests_failed++; $display("FAIL full_step got lvl=%0d num=%h exp 3 0011", level, num);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_after got %b exp 1", in_ready); end
    tick(4);
    tests_run++;
    if (num !== 16'h1122 || level !== 3'd2) begin
      tests_failed++; $display("FAIL full_order got num=%h lvl=%0d exp 1122 2", num, level);
    end
  endtask

  task automatic test_push_on_step();
    do_reset();
    tick(3);
    in_valid = 1'b1; in_data = 8'h9C;
    tick(1);
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd1 || num !== 16'h0000 || aen !== 4'hF) begin
      tests_failed++; $display("FAIL pos_nopop got lvl=%0d num=%h aen=%h exp 1 0000 f", level, num, aen);
    end
    tick(4);
    tests_run++;
    if (level !== 3'd0 || num !== 16'h009C) begin
      tests_failed++; $display("FAIL pos_next got lvl=%0d num=%h exp 0 009c", level, num);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hAA + 8'(i * 17);
      tick(1);
    end
    in_valid = 1'b0;
    tick(2);
    tests_run++;
    if (num !== 16'h00AA || level !== 3'd2) begin
      tests_failed++; $display("FAIL clr_setup got num=%h lvl=%0d exp 00aa 2", num, level);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hDD;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL clr_ready got %b exp 0", in_ready); end
    tick(1);
    clear = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd0 || num !== 16'h0000 || aen !== 4'hF) begin
      tests_failed++; $display("FAIL clr_result got lvl=%0d num=%h aen=%h exp 0 0000 f", level, num, aen);
    end
    tick(4);
    tests_run++;
    if (level !== 3'd0 || num !== 16'h0000) begin
      tests_failed++; $display("FAIL clr_dropped got lvl=%0d num=%h exp 0 0000", level, num);
    end
  endtask

  task automatic test_empty_then_rst();
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    tick(1);
    in_valid = 1'b0;
    tick(3);
    tick(12);
    tests_run++;
    if (num !== 16'h0077 || aen !== 4'hC || level !== 3'd0) begin
      tests_failed++; $display("FAIL empty_stable got num=%h aen=%h lvl=%0d exp 0077 c 0", num, aen, level);
    end
    in_valid = 1'b1; in_data = 8'h01;
    tick(1);
    in_data = 8'h02;
    tick(1);
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd2) begin tests_failed++; $display("FAIL rst_setup got lvl=%0d exp 2", level); end
    rst = 1'b1;
    tick(1);
    tests_run++;
    if (num !== 16'h0000 || aen !== 4'hF || level !== 3'd0 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid got num=%h aen=%h lvl=%0d rdy=%b exp 0000 f 0 0", num, aen, level, in_ready);
    end
    rst = 1'b0;
    tick(4);
    tests_run++;
    if (num !== 16'h0000 || level !== 3'd0) begin
      tests_failed++; $display("FAIL rst_discard got num=%h lvl=%0d exp 0000 0", num, level);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; clear = 1'b0; hold = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(2);
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_full_step();
    test_push_on_step();
    test_clear();
    test_empty_then_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_scroller.md
SEG_SCROLLER -- requirements
Module: seg_scroller

Interface
REQ-001 Parameter DEPTH, default 8: byte FIFO depth; power of two, >=2.
REQ-002 Parameter DWELL, default 50_000_000: clk cycles per scroll step, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 clear  input  1  synchronous flush of FIFO and display.
REQ-006 hold  input  1  freezes scrolling while high.
REQ-007 in_data  input  8  byte to display, two hex digits.
REQ-008 in_valid  input  1  in_data valid this cycle.
REQ-009 in_ready  output  1  block can accept a byte this cycle.
REQ-010 num  output  16  four hex digits to the seven-segment driver; [15:12] leftmost.
REQ-011 aen  output  4  per-digit disable to the driver; 1 = digit blanked.
REQ-012 level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-013 Push: a byte is accepted on a cycle with in_valid=1, in_ready=1, rst=0, clear=0.
REQ-014 in_ready is combinational: 1 when level<DEPTH and clear=0, else 0; no push-on-pop bypass when full.
REQ-015 FIFO order is strict first-in first-out; write/read pointers wrap modulo DEPTH.
REQ-016 Dwell counter counts 0..DWELL-1 and wraps to 0; it advances only when hold=0.
REQ-017 Step event: dwell counter equals DWELL-1 and hold=0.
REQ-018 On step with level>0: pop head byte; next num = {num[7:0], head}; next aen = {aen[1:0], 2'b00}.
REQ-019 On step with level=0: num and aen unchanged; no pop.
REQ-020 Push and pop in the same cycle: both take effect; level unchanged.
REQ-021 A byte pushed on the step cycle itself is not popped that cycle; it is only eligible from the next step.
REQ-022 level updates the cycle after push/pop; it never exceeds DEPTH and never underflows.
REQ-023 Scroll latency: byte pushed into an empty FIFO at cycle t appears in num[7:0] at the first step after t, i.e. within DWELL cycles (hold=0).
REQ-024 hold=1: dwell counter, num, aen frozen; pushes continue until full.
REQ-025 clear=1 (rst=0): pointers and level -> 0, num -> 16'h0000, aen -> 4'hF, dwell counter -> 0; any in_valid that cycle is dropped.
REQ-026 clear has priority over step and push; rst has priority over clear.
REQ-027 num, aen, level are registered; in_ready is the only combinational output.
REQ-028 After 2 steps with data from reset, aen = 4'h0; it stays 0 until rst/clear.

Reset
REQ-029 rst=1 at a clock edge: num=16'h0000, aen=4'hF, level=0, pointers=0, dwell counter=0.
REQ-030 in_ready=0 while rst=1; FIFO storage contents need not be reset.
REQ-031 rst asserted mid-dwell or mid-scroll discards all buffered bytes; no partial shift is observable.

Structure
REQ-032 Shared package holds DEPTH/DWELL defaults and the blank-mask constant 4'hF.
REQ-033 One sub-module, seg_byte_fifo (push/pop/level/clear, parameter DEPTH); dwell counter and display shift register live in seg_scroller.
REQ-034 Dwell counter width = clog2(DWELL); comparisons use the full counter width.
REQ-035 num/aen drive the seven-segment driver's num/aen directly, no extra logic.

Verification (DEPTH=4, DWELL=4)
REQ-036 After rst, push 8'hA5 -> within 4 cycles num=16'h00A5, aen=4'hC, level=0.
REQ-037 Push 8'h12, 8'h34, 8'h56 back-to-back, hold=0 -> after successive steps num = 16'h0012, 16'h1234, 16'h3456; aen = 4'hC, then 4'h0.
REQ-038 hold=1, push 5 bytes continuously -> 4 accepted, in_ready=0 with level=4; num unchanged until hold=0.
REQ-039 Full FIFO, push offered on the step cycle -> pop occurs, push refused; level=3 next cycle; in_ready=1 from the following cycle.
REQ-040 clear together with in_valid mid-dwell at level=2 -> next cycle level=0, num=0, aen=4'hF; the byte offered is dropped.
REQ-041 Empty FIFO across 3 steps -> num/aen stable; rst mid-dwell at level=2 -> all reset values the next cycle.
